// File: rtl/matrix_store_ctrl_pkg.sv
// ============================================================================
// Module : matrix_store_ctrl_pkg
// Brief  : Shared widths, error codes, FSM states and helpers for the matrix
//          store controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package matrix_store_ctrl_pkg;

    localparam int c_ELEMENT_WIDTH = 16;
    localparam int c_MAX_DIM       = 5;
    localparam int c_DIM_W         = 5;
    localparam int c_SLOT_W        = 4;
    localparam int c_ADDR_W        = 12;
    localparam int c_CNT_W         = 10;

    localparam logic [c_SLOT_W-1:0] c_SLOT_NONE = 4'hF;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_BAD_DIM  = 2'd1,
        ERR_NO_SPACE = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ALLOC_REQ  = 3'd1,
        ST_ALLOC_WAIT = 3'd2,
        ST_WRITE      = 3'd3,
        ST_COMMIT     = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

    function automatic logic dim_legal(input logic [c_DIM_W-1:0] d,
                                       input logic [c_DIM_W-1:0] max_dim);
        return (d != '0) && (d <= max_dim);
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_store_ctrl_idle_timer.sv
// ============================================================================
// Module : matrix_store_ctrl_idle_timer
// Brief  : Counts idle cycles between stream elements; flags expiry on the
//          TIMEOUT_CYCLES-th consecutive idle cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module matrix_store_ctrl_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int                  c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign expire = inc & (r_cnt == c_LAST);

    // Saturates at the last value so a held request cannot wrap past expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/matrix_store_ctrl.sv
// ============================================================================
// Module : matrix_store_ctrl
// Brief  : Write-side controller: validates m x n, runs the manager alloc
//          handshake, streams elements to BRAM and issues the commit pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module matrix_store_ctrl
    import matrix_store_ctrl_pkg::*;
#(
    parameter int ELEMENT_WIDTH  = c_ELEMENT_WIDTH,
    parameter int MAX_DIM        = c_MAX_DIM,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [c_DIM_W-1:0]       in_m,
    input  logic [c_DIM_W-1:0]       in_n,
    input  logic                     elem_valid,
    input  logic [ELEMENT_WIDTH-1:0] elem_data,
    output logic                     elem_ready,
    output logic                     alloc_req,
    output logic [c_DIM_W-1:0]       alloc_m,
    output logic [c_DIM_W-1:0]       alloc_n,
    input  logic                     alloc_valid,
    input  logic [c_SLOT_W-1:0]      alloc_slot,
    input  logic [c_ADDR_W-1:0]      alloc_addr,
    output logic                     bram_we,
    output logic [c_ADDR_W-1:0]      bram_addr,
    output logic [ELEMENT_WIDTH-1:0] bram_wdata,
    output logic                     commit_req,
    output logic [c_SLOT_W-1:0]      commit_slot,
    output logic [c_DIM_W-1:0]       commit_m,
    output logic [c_DIM_W-1:0]       commit_n,
    output logic [c_ADDR_W-1:0]      commit_addr,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err_code,
    output logic [c_SLOT_W-1:0]      slot_out
);

    localparam logic [c_DIM_W-1:0] c_MAX_DIM_V = c_DIM_W'(MAX_DIM);

    state_e              r_state;
    err_e                r_err;
    logic [c_SLOT_W-1:0] r_slot;
    logic [c_ADDR_W-1:0] r_base;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  r_total;

    logic                w_xfer;
    logic                w_last;
    logic                w_legal;
    logic                w_expire;
    logic [c_CNT_W-1:0]  w_total;

    assign w_total = c_CNT_W'(in_m) * c_CNT_W'(in_n);
    assign w_legal = dim_legal(in_m, c_MAX_DIM_V) && dim_legal(in_n, c_MAX_DIM_V);
    assign w_xfer  = elem_valid & elem_ready;
    assign w_last  = (r_cnt == r_total - c_CNT_W'(1));

    matrix_store_ctrl_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((r_state == ST_ALLOC_WAIT) | w_xfer),
        .inc    ((r_state == ST_WRITE) & ~w_xfer),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_err       <= ERR_OK;
            r_slot      <= '0;
            r_base      <= '0;
            r_cnt       <= '0;
            r_total     <= '0;
            elem_ready  <= 1'b0;
            alloc_req   <= 1'b0;
            alloc_m     <= '0;
            alloc_n     <= '0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_wdata  <= '0;
            commit_req  <= 1'b0;
            commit_slot <= '0;
            commit_m    <= '0;
            commit_n    <= '0;
            commit_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_code    <= '0;
            slot_out    <= c_SLOT_NONE;
        end else begin
            alloc_req  <= 1'b0;
            bram_we    <= 1'b0;
            commit_req <= 1'b0;
            done       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        alloc_m <= in_m;
                        alloc_n <= in_n;
                        r_total <= w_total;
                        busy    <= 1'b1;
                        if (w_legal) begin
                            alloc_req <= 1'b1;
                            r_state   <= ST_ALLOC_REQ;
                        end else begin
                            r_err   <= ERR_BAD_DIM;
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_ALLOC_REQ: begin
                    r_state <= ST_ALLOC_WAIT;
                end

                // The manager answers from a register, so the grant is only
                // meaningful in this single cycle.
                ST_ALLOC_WAIT: begin
                    if (alloc_valid) begin
                        r_slot     <= alloc_slot;
                        r_base     <= alloc_addr;
                        r_cnt      <= '0;
                        elem_ready <= 1'b1;
                        r_state    <= ST_WRITE;
                    end else begin
                        r_err   <= ERR_NO_SPACE;
                        r_state <= ST_DONE;
                    end
                end

                ST_WRITE: begin
                    if (w_xfer) begin
                        bram_we    <= 1'b1;
                        bram_addr  <= r_base + {2'b00, r_cnt};
                        bram_wdata <= elem_data;
                        r_cnt      <= r_cnt + c_CNT_W'(1);
                        if (w_last) begin
                            elem_ready <= 1'b0;
                            r_state    <= ST_COMMIT;
                        end
                    end else if (w_expire) begin
                        elem_ready <= 1'b0;
                        r_err      <= ERR_TIMEOUT;
                        r_state    <= ST_DONE;
                    end
                end

                ST_COMMIT: begin
                    commit_req  <= 1'b1;
                    commit_slot <= r_slot;
                    commit_m    <= alloc_m;
                    commit_n    <= alloc_n;
                    commit_addr <= r_base;
                    r_err       <= ERR_OK;
                    r_state     <= ST_DONE;
                end

                ST_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    err_code <= r_err;
                    slot_out <= (r_err == ERR_OK) ? r_slot : c_SLOT_NONE;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
